// File: rtl/reorder_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer_if
// Description : Issue / writeback / query / commit / rollback bundle for the
//               reorder buffer. master = surrounding pipeline, slave = ROB.
// Revision    : 1.0 - initial release
// ============================================================================
interface reorder_buffer_if #(
    parameter int POS_WID = 4
);
    logic               rollback;
    logic [31:0]        rollback_pc;
    logic               rob_full;

    logic               issue;
    logic [1:0]         issue_type;
    logic [4:0]         issue_rd;
    logic [31:0]        issue_pc;
    logic               issue_pred_jump;
    logic [POS_WID-1:0] issue_rob_pos;

    logic [POS_WID-1:0] query_pos1;
    logic               query_ready1;
    logic [31:0]        query_val1;
    logic [POS_WID-1:0] query_pos2;
    logic               query_ready2;
    logic [31:0]        query_val2;

    logic               alu_result;
    logic [POS_WID-1:0] alu_rob_pos;
    logic [31:0]        alu_val;
    logic               alu_jump;
    logic [31:0]        alu_target;

    logic               lsb_result;
    logic [POS_WID-1:0] lsb_rob_pos;
    logic [31:0]        lsb_val;

    logic               rob_commit;
    logic [4:0]         rob_commit_rd;
    logic [31:0]        rob_commit_val;
    logic [POS_WID-1:0] rob_commit_rob_pos;
    logic               commit_store;

    modport master (
        input  rollback, rollback_pc, rob_full, issue_rob_pos,
        input  query_ready1, query_val1, query_ready2, query_val2,
        input  rob_commit, rob_commit_rd, rob_commit_val, rob_commit_rob_pos, commit_store,
        output issue, issue_type, issue_rd, issue_pc, issue_pred_jump,
        output query_pos1, query_pos2,
        output alu_result, alu_rob_pos, alu_val, alu_jump, alu_target,
        output lsb_result, lsb_rob_pos, lsb_val
    );

    modport slave (
        output rollback, rollback_pc, rob_full, issue_rob_pos,
        output query_ready1, query_val1, query_ready2, query_val2,
        output rob_commit, rob_commit_rd, rob_commit_val, rob_commit_rob_pos, commit_store,
        input  issue, issue_type, issue_rd, issue_pc, issue_pred_jump,
        input  query_pos1, query_pos2,
        input  alu_result, alu_rob_pos, alu_val, alu_jump, alu_target,
        input  lsb_result, lsb_rob_pos, lsb_val
    );
endinterface
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer
// Description : Circular in-order retirement buffer with result capture,
//               operand query, register/store commit and mispredict rollback.
//               Optional macro ROB_FORWARD_EN bypasses same-cycle broadcasts
//               onto the query ports.
// Revision    : 1.0 - initial release
// ============================================================================
module reorder_buffer #(
    parameter int ROB_SIZE = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        rdy,
    reorder_buffer_if.slave  bus
);
    localparam int c_POS_WID = $clog2(ROB_SIZE);
    localparam int c_CNT_WID = c_POS_WID + 1;
    localparam logic [c_CNT_WID-1:0] c_FULL = c_CNT_WID'(ROB_SIZE);

    typedef enum logic [1:0] {
        TYPE_REG    = 2'd0,
        TYPE_BRANCH = 2'd1,
        TYPE_STORE  = 2'd2
    } entry_type_e;

    logic                 r_busy   [ROB_SIZE];
    logic                 r_ready  [ROB_SIZE];
    entry_type_e          r_type   [ROB_SIZE];
    logic [4:0]           r_rd     [ROB_SIZE];
    logic [31:0]          r_pc     [ROB_SIZE];
    logic                 r_pred   [ROB_SIZE];
    logic [31:0]          r_val    [ROB_SIZE];
    logic                 r_jump   [ROB_SIZE];
    logic [31:0]          r_target [ROB_SIZE];

    logic [c_POS_WID-1:0] r_head;
    logic [c_POS_WID-1:0] r_tail;
    logic [c_CNT_WID-1:0] r_count;

    logic                 r_rollback;
    logic [31:0]          r_rollback_pc;
    logic                 r_commit;
    logic [4:0]           r_commit_rd;
    logic [31:0]          r_commit_val;
    logic [c_POS_WID-1:0] r_commit_pos;
    logic                 r_commit_store;

    logic w_full;
    logic w_issue_ok;
    logic w_commit;

    assign w_full     = (r_count == c_FULL);
    assign w_issue_ok = bus.issue && !w_full && !r_rollback;
    assign w_commit   = r_busy[r_head] && r_ready[r_head] && !r_rollback;

    assign bus.rob_full           = w_full;
    assign bus.issue_rob_pos      = r_tail;
    assign bus.rollback           = r_rollback;
    assign bus.rollback_pc        = r_rollback_pc;
    assign bus.rob_commit         = r_commit;
    assign bus.rob_commit_rd      = r_commit_rd;
    assign bus.rob_commit_val     = r_commit_val;
    assign bus.rob_commit_rob_pos = r_commit_pos;
    assign bus.commit_store       = r_commit_store;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_rollback     <= 1'b0;
            r_rollback_pc  <= '0;
            r_commit       <= 1'b0;
            r_commit_rd    <= '0;
            r_commit_val   <= '0;
            r_commit_pos   <= '0;
            r_commit_store <= 1'b0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                r_busy[i]  <= 1'b0;
                r_ready[i] <= 1'b0;
            end
        end else if (rdy) begin
            r_commit       <= 1'b0;
            r_commit_store <= 1'b0;
            if (r_rollback) begin
                r_rollback <= 1'b0;
                r_head     <= '0;
                r_tail     <= '0;
                r_count    <= '0;
                for (int i = 0; i < ROB_SIZE; i++) begin
                    r_busy[i]  <= 1'b0;
                    r_ready[i] <= 1'b0;
                end
            end else begin
                if (w_issue_ok) begin
                    r_busy[r_tail]  <= 1'b1;
                    r_ready[r_tail] <= (bus.issue_type == TYPE_STORE);
                    r_type[r_tail]  <= entry_type_e'(bus.issue_type);
                    r_rd[r_tail]    <= bus.issue_rd;
                    r_pc[r_tail]    <= bus.issue_pc;
                    r_pred[r_tail]  <= bus.issue_pred_jump;
                    r_tail          <= r_tail + 1'b1;
                end
                if (bus.alu_result && r_busy[bus.alu_rob_pos]) begin
                    r_ready[bus.alu_rob_pos]  <= 1'b1;
                    r_val[bus.alu_rob_pos]    <= bus.alu_val;
                    r_jump[bus.alu_rob_pos]   <= bus.alu_jump;
                    r_target[bus.alu_rob_pos] <= bus.alu_target;
                end
                if (bus.lsb_result && r_busy[bus.lsb_rob_pos]) begin
                    r_ready[bus.lsb_rob_pos] <= 1'b1;
                    r_val[bus.lsb_rob_pos]   <= bus.lsb_val;
                end
                // Commit clears come last so a late broadcast cannot revive a retired entry.
                if (w_commit) begin
                    r_busy[r_head]  <= 1'b0;
                    r_ready[r_head] <= 1'b0;
                    r_head          <= r_head + 1'b1;
                    case (r_type[r_head])
                        TYPE_REG: begin
                            r_commit     <= 1'b1;
                            r_commit_rd  <= r_rd[r_head];
                            r_commit_val <= r_val[r_head];
                            r_commit_pos <= r_head;
                        end
                        TYPE_STORE: r_commit_store <= 1'b1;
                        TYPE_BRANCH: begin
                            if (r_jump[r_head] != r_pred[r_head]) begin
                                r_rollback    <= 1'b1;
                                r_rollback_pc <= r_jump[r_head] ? r_target[r_head]
                                                                : r_pc[r_head] + 32'd4;
                            end
                        end
                        default: ;
                    endcase
                end
                case ({w_issue_ok, w_commit})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_comb begin
        bus.query_ready1 = r_busy[bus.query_pos1] && r_ready[bus.query_pos1];
        bus.query_val1   = r_val[bus.query_pos1];
        bus.query_ready2 = r_busy[bus.query_pos2] && r_ready[bus.query_pos2];
        bus.query_val2   = r_val[bus.query_pos2];
`ifdef ROB_FORWARD_EN
        if (bus.alu_result && bus.alu_rob_pos == bus.query_pos1) begin
            bus.query_ready1 = 1'b1;
            bus.query_val1   = bus.alu_val;
        end else if (bus.lsb_result && bus.lsb_rob_pos == bus.query_pos1) begin
            bus.query_ready1 = 1'b1;
            bus.query_val1   = bus.lsb_val;
        end
        if (bus.alu_result && bus.alu_rob_pos == bus.query_pos2) begin
            bus.query_ready2 = 1'b1;
            bus.query_val2   = bus.alu_val;
        end else if (bus.lsb_result && bus.lsb_rob_pos == bus.query_pos2) begin
            bus.query_ready2 = 1'b1;
            bus.query_val2   = bus.lsb_val;
        end
`endif
    end
endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reorder_buffer
// Description : Directed self-checking bench for reorder_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    reorder_buffer_if #(.POS_WID(4)) bus ();

    reorder_buffer #(.ROB_SIZE(16)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.issue = 1'b0; bus.issue_type = 2'd0; bus.issue_rd = '0; bus.issue_pc = '0;
        bus.issue_pred_jump = 1'b0; bus.query_pos1 = '0; bus.query_pos2 = '0;
        bus.alu_result = 1'b0; bus.alu_rob_pos = '0; bus.alu_val = '0;
        bus.alu_jump = 1'b0; bus.alu_target = '0;
        bus.lsb_result = 1'b0; bus.lsb_rob_pos = '0; bus.lsb_val = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rdy = 1'b1;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic do_issue(input logic [1:0] t, input logic [4:0] rd,
                            input logic [31:0] pc, input logic pred);
        bus.issue = 1'b1; bus.issue_type = t; bus.issue_rd = rd;
        bus.issue_pc = pc; bus.issue_pred_jump = pred;
        step();
        bus.issue = 1'b0;
    endtask

    task automatic do_alu(input logic [3:0] pos, input logic [31:0] val,
                          input logic jump, input logic [31:0] target);
        bus.alu_result = 1'b1; bus.alu_rob_pos = pos; bus.alu_val = val;
        bus.alu_jump = jump; bus.alu_target = target;
        step();
        bus.alu_result = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst_rollback", 32'(bus.rollback), 32'd0);
        check("rst_commit", 32'(bus.rob_commit), 32'd0);
        check("rst_store", 32'(bus.commit_store), 32'd0);
        check("rst_tail", 32'(bus.issue_rob_pos), 32'd0);
        check("rst_full", 32'(bus.rob_full), 32'd0);
        check("rst_count", 32'(dut.r_count), 32'd0);

        // Single REG instruction end to end
        do_issue(2'd0, 5'd5, 32'h0, 1'b0);
        check("t1_tail", 32'(bus.issue_rob_pos), 32'd1);
        do_alu(4'd0, 32'h1234, 1'b0, 32'h0);
        check("t1_no_early_commit", 32'(bus.rob_commit), 32'd0);
        step();
        check("t1_commit", 32'(bus.rob_commit), 32'd1);
        check("t1_rd", 32'(bus.rob_commit_rd), 32'd5);
        check("t1_val", bus.rob_commit_val, 32'h1234);
        check("t1_pos", 32'(bus.rob_commit_rob_pos), 32'd0);
        check("t1_count", 32'(dut.r_count), 32'd0);
        step();
        check("t1_pulse_end", 32'(bus.rob_commit), 32'd0);

        // Fill, overflow attempt, wrap-around
        do_reset();
        for (int i = 0; i < 16; i++) begin
            check("t2_alloc_pos", 32'(bus.issue_rob_pos), 32'(i));
            do_issue(2'd0, 5'(i), 32'(i * 4), 1'b0);
        end
        check("t2_full", 32'(bus.rob_full), 32'd1);
        check("t2_tail_wrap", 32'(bus.issue_rob_pos), 32'd0);
        do_issue(2'd0, 5'd31, 32'hFFF0, 1'b0);
        check("t2_overflow_count", 32'(dut.r_count), 32'd16);
        check("t2_overflow_tail", 32'(bus.issue_rob_pos), 32'd0);
        do_alu(4'd0, 32'hA0, 1'b0, 32'h0);
        step();
        check("t2_commit", 32'(bus.rob_commit), 32'd1);
        check("t2_commit_pos", 32'(bus.rob_commit_rob_pos), 32'd0);
        check("t2_not_full", 32'(bus.rob_full), 32'd0);
        check("t2_new_pos", 32'(bus.issue_rob_pos), 32'd0);
        do_issue(2'd0, 5'd9, 32'h40, 1'b0);
        check("t2_full_again", 32'(bus.rob_full), 32'd1);

        // Out-of-order completion, in-order retirement
        do_reset();
        for (int i = 0; i < 3; i++) do_issue(2'd0, 5'(i + 1), 32'(i * 4), 1'b0);
        do_alu(4'd2, 32'h22, 1'b0, 32'h0);
        do_alu(4'd1, 32'h11, 1'b0, 32'h0);
        check("t3_blocked", 32'(bus.rob_commit), 32'd0);
        do_alu(4'd0, 32'h10, 1'b0, 32'h0);
        step();
        check("t3_c0_pos", 32'(bus.rob_commit_rob_pos), 32'd0);
        check("t3_c0_val", bus.rob_commit_val, 32'h10);
        step();
        check("t3_c1_pos", 32'(bus.rob_commit_rob_pos), 32'd1);
        check("t3_c1_val", bus.rob_commit_val, 32'h11);
        step();
        check("t3_c2_pos", 32'(bus.rob_commit_rob_pos), 32'd2);
        check("t3_c2_rd", 32'(bus.rob_commit_rd), 32'd3);
        check("t3_c2_commit", 32'(bus.rob_commit), 32'd1);
        step();
        check("t3_idle", 32'(bus.rob_commit), 32'd0);
        check("t3_count", 32'(dut.r_count), 32'd0);

        // Mispredict: predicted not-taken, actually taken
        do_reset();
        do_issue(2'd1, 5'd0, 32'h100, 1'b0);
        do_issue(2'd0, 5'd7, 32'h104, 1'b0);
        do_issue(2'd0, 5'd8, 32'h108, 1'b0);
        bus.lsb_result = 1'b1; bus.lsb_rob_pos = 4'd1; bus.lsb_val = 32'h77;
        do_alu(4'd0, 32'h0, 1'b1, 32'h200);
        bus.lsb_result = 1'b0;
        step();
        check("t4a_rollback", 32'(bus.rollback), 32'd1);
        check("t4a_pc", bus.rollback_pc, 32'h200);
        check("t4a_no_reg_commit", 32'(bus.rob_commit), 32'd0);
        bus.issue = 1'b1; bus.issue_type = 2'd0;
        step();
        bus.issue = 1'b0;
        check("t4a_rb_end", 32'(bus.rollback), 32'd0);
        check("t4a_count", 32'(dut.r_count), 32'd0);
        check("t4a_tail", 32'(bus.issue_rob_pos), 32'd0);
        step();
        check("t4a_young_flushed", 32'(bus.rob_commit), 32'd0);

        // Mispredict: predicted taken, actually not taken
        do_reset();
        do_issue(2'd1, 5'd0, 32'h100, 1'b1);
        do_alu(4'd0, 32'h0, 1'b0, 32'h300);
        step();
        check("t4b_rollback", 32'(bus.rollback), 32'd1);
        check("t4b_pc", bus.rollback_pc, 32'h104);
        step();
        check("t4b_rb_end", 32'(bus.rollback), 32'd0);

        // Correctly predicted branch, then a store
        do_reset();
        do_issue(2'd1, 5'd0, 32'h80, 1'b1);
        do_issue(2'd2, 5'd0, 32'h84, 1'b0);
        do_alu(4'd0, 32'h0, 1'b1, 32'h400);
        step();
        check("t4c_no_rollback", 32'(bus.rollback), 32'd0);
        step();
        check("t4c_store", 32'(bus.commit_store), 32'd1);
        check("t4c_store_no_reg", 32'(bus.rob_commit), 32'd0);
        step();
        check("t4c_store_end", 32'(bus.commit_store), 32'd0);

        // Simultaneous issue + commit, then rdy freeze
        do_reset();
        for (int i = 0; i < 8; i++) do_issue(2'd0, 5'(i), 32'(i * 4), 1'b0);
        check("t5_count8", 32'(dut.r_count), 32'd8);
        do_alu(4'd0, 32'h5, 1'b0, 32'h0);
        do_issue(2'd0, 5'd20, 32'h20, 1'b0);
        check("t5_commit", 32'(bus.rob_commit), 32'd1);
        check("t5_count_same", 32'(dut.r_count), 32'd8);
        check("t5_tail", 32'(bus.issue_rob_pos), 32'd9);
        step();
        rdy = 1'b0;
        bus.issue = 1'b1; bus.issue_type = 2'd0;
        bus.alu_result = 1'b1; bus.alu_rob_pos = 4'd1; bus.alu_val = 32'h99;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_frz_tail", 32'(bus.issue_rob_pos), 32'd9);
            check("t5_frz_count", 32'(dut.r_count), 32'd8);
            check("t5_frz_pulse", 32'(bus.rob_commit), 32'd0);
        end
        clear_inputs();
        rdy = 1'b1;
        step();
        check("t5_frz_no_wb", 32'(bus.rob_commit), 32'd0);
        check("t5_resume_count", 32'(dut.r_count), 32'd8);

        // Query path and same-cycle broadcast visibility
        do_reset();
        for (int i = 0; i < 4; i++) do_issue(2'd0, 5'(i), 32'(i * 4), 1'b0);
        bus.query_pos1 = 4'd3; bus.query_pos2 = 4'd9;
        bus.alu_result = 1'b1; bus.alu_rob_pos = 4'd3; bus.alu_val = 32'hDEAD;
        bus.lsb_result = 1'b1; bus.lsb_rob_pos = 4'd9; bus.lsb_val = 32'hBEEF;
        #1;
`ifdef ROB_FORWARD_EN
        check("t6_fwd_ready", 32'(bus.query_ready1), 32'd1);
        check("t6_fwd_val", bus.query_val1, 32'hDEAD);
`else
        check("t6_nofwd_ready", 32'(bus.query_ready1), 32'd0);
`endif
        step();
        clear_inputs();
        bus.query_pos1 = 4'd3; bus.query_pos2 = 4'd9;
        #1;
        check("t6_next_ready", 32'(bus.query_ready1), 32'd1);
        check("t6_next_val", bus.query_val1, 32'hDEAD);
        check("t6_idle_entry", 32'(bus.query_ready2), 32'd0);
        bus.query_pos2 = 4'd2;
        #1;
        check("t6_pending_entry", 32'(bus.query_ready2), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
